// File: rtl/va_sweep_pkg.sv
// va_sweep_pkg: shared types and ctrl_word field layout for the VA sweep controller.
// Contents: sweep FSM state enum, bit offsets/widths of the HPS PIO control word.
package va_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // ctrl_word layout: [0] start, [1] abort, [9:2] npts_m1, [21:10] settle, [31:22] reserved
  localparam int unsigned START_BIT  = 0;
  localparam int unsigned ABORT_BIT  = 1;
  localparam int unsigned NPTS_LSB   = 2;
  localparam int unsigned NPTS_FW    = 8;
  localparam int unsigned SETTLE_LSB = 10;
  localparam int unsigned SETTLE_FW  = 12;
  localparam int unsigned RSVD_LSB   = 22;

endpackage

// File: rtl/va_sweep_timer.sv
// va_sweep_timer: loadable saturating down-counter with a registered zero flag.
// Ports:
//   clk_i      - clock (rising edge)
//   rst_ni     - synchronous active-low reset
//   load_i     - load load_val_i (wins over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one, holding at zero
//   zero_o     - count is zero (registered alongside the count)
module va_sweep_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/va_sweep_ctrl.sv
// va_sweep_ctrl: steps a vector-analyser sweep through npts_m1+1 frequency points,
// settling the generator then handshaking a capture at each point.
// Ports:
//   clk_clk       - clock (rising edge)
//   reset_reset_n - synchronous active-low reset
//   ctrl_word     - [0] start (rising edge), [1] abort, [9:2] npts_m1, [21:10] settle
//   cap_ack       - capture engine accepted the current point
//   gen_en        - vector generator enable (SETTLE and CAPTURE)
//   freq_idx      - current sweep point
//   cap_req       - capture request for the current point
//   busy          - controller not idle
//   done          - one-cycle pulse at sweep completion
//   err_timeout   - sticky capture-ack timeout flag
// Optional feature: define VA_SWEEP_ACK_TIMEOUT_EN to abandon a sweep after ACK_TO
// consecutive CAPTURE clocks without cap_ack; otherwise CAPTURE waits indefinitely.
module va_sweep_ctrl
  import va_sweep_pkg::*;
#(
  parameter int unsigned NPTS_W   = 8,
  parameter int unsigned SETTLE_W = 12,
  parameter int unsigned ACK_TO   = 4095
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       ctrl_word,
  input  logic              cap_ack,
  output logic              gen_en,
  output logic [NPTS_W-1:0] freq_idx,
  output logic              cap_req,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  state_e              state_q, state_d;
  logic [NPTS_W-1:0]   freq_q, freq_d;
  logic [NPTS_W-1:0]   npts_q, npts_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                start_prev_q;
  logic                seen_low_q;
  logic                gen_en_q, cap_req_q, busy_q, done_q;

  logic                start_c, abort_c, start_edge_c;
  logic [NPTS_W-1:0]   npts_fld_c;
  logic [SETTLE_W-1:0] settle_fld_c;
  logic                settle_load_c, settle_dec_c, settle_zero_c;
  logic [SETTLE_W-1:0] settle_val_c;

  assign start_c      = ctrl_word[START_BIT];
  assign abort_c      = ctrl_word[ABORT_BIT];
  assign npts_fld_c   = NPTS_W'(ctrl_word[NPTS_LSB +: NPTS_FW]);
  assign settle_fld_c = SETTLE_W'(ctrl_word[SETTLE_LSB +: SETTLE_FW]);
  // seen_low_q blocks a start level that was already high across reset release.
  assign start_edge_c = start_c && !start_prev_q && seen_low_q;

  logic unused_c;
  assign unused_c = ^{ctrl_word[31:RSVD_LSB], (ACK_TO == 32'd0)};

  va_sweep_timer #(.W(SETTLE_W)) u_settle_tmr (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .load_i     (settle_load_c),
    .load_val_i (settle_val_c),
    .dec_i      (settle_dec_c),
    .zero_o     (settle_zero_c)
  );

`ifdef VA_SWEEP_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ACK_TO + 1);

  logic            to_load_c, to_dec_c, to_zero_c;
  logic            err_q, err_d;

  // Loaded with ACK_TO-1 on CAPTURE entry so zero marks the ACK_TO-th CAPTURE clock.
  va_sweep_timer #(.W(TO_W)) u_ack_tmr (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .load_i     (to_load_c),
    .load_val_i (TO_W'(ACK_TO - 1)),
    .dec_i      (to_dec_c),
    .zero_o     (to_zero_c)
  );

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    npts_d        = npts_q;
    settle_d      = settle_q;
    settle_load_c = 1'b0;
    settle_dec_c  = 1'b0;
    settle_val_c  = settle_q;
`ifdef VA_SWEEP_ACK_TIMEOUT_EN
    err_d         = err_q;
    to_load_c     = 1'b0;
    to_dec_c      = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Abort in the same cycle as a start edge suppresses the start.
        if (start_edge_c && !abort_c) begin
          state_d       = ST_SETTLE;
          npts_d        = npts_fld_c;
          settle_d      = settle_fld_c;
          freq_d        = '0;
          settle_load_c = 1'b1;
          settle_val_c  = settle_fld_c;
`ifdef VA_SWEEP_ACK_TIMEOUT_EN
          err_d         = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        if (abort_c) begin
          state_d = ST_IDLE;
        end else if (settle_zero_c) begin
          state_d = ST_CAPTURE;
`ifdef VA_SWEEP_ACK_TIMEOUT_EN
          to_load_c = 1'b1;
`endif
        end else begin
          settle_dec_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (abort_c) begin
          state_d = ST_IDLE;
        end else if (cap_ack) begin
          if (freq_q == npts_q) begin
            state_d = ST_DONE;
          end else begin
            state_d       = ST_SETTLE;
            freq_d        = freq_q + NPTS_W'(1);
            settle_load_c = 1'b1;
          end
        end
`ifdef VA_SWEEP_ACK_TIMEOUT_EN
        else if (to_zero_c) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_dec_c = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      freq_q       <= '0;
      npts_q       <= '0;
      settle_q     <= '0;
      start_prev_q <= 1'b0;
      seen_low_q   <= ~start_c;
      gen_en_q     <= 1'b0;
      cap_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef VA_SWEEP_ACK_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      npts_q       <= npts_d;
      settle_q     <= settle_d;
      start_prev_q <= start_c;
      seen_low_q   <= seen_low_q | ~start_c;
      gen_en_q     <= (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
      cap_req_q    <= (state_d == ST_CAPTURE);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
`ifdef VA_SWEEP_ACK_TIMEOUT_EN
      err_q        <= err_d;
`endif
    end
  end

  assign gen_en   = gen_en_q;
  assign cap_req  = cap_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign freq_idx = freq_q;

endmodule
